// File: rtl/led_pkg.sv
// led_pkg: shared helpers and slot-state encoding for the LED scan driver.
package led_pkg;
   typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} slot_state_e;
   // Ceiling log2, never below 1 so single-value ranges still get a bit.
   function automatic int clog2(input int v);
      int r;
      r = 1;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic logic [63:0] seg_blank(input int w);
      return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
   endfunction
endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: slot timebase counting 0..SLOT_CYCLES-1 with synchronous clear.
module led_prescaler import led_pkg::*; #(
   parameter int SLOT_CYCLES = 1000000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   output logic                          slot_end,
   output logic [clog2(SLOT_CYCLES)-1:0] count
);
   localparam int CW = clog2(SLOT_CYCLES);
   logic [CW-1:0] count_d, count_q;
   always_comb begin
      slot_end = count_q == CW'(SLOT_CYCLES - 1);
      count_d = (clear || slot_end) ? '0 : count_q + 1'b1;
   end
   always_ff @(posedge clk)
      if (rst) count_q <= '0;
      else count_q <= count_d;
   assign count = count_q;
endmodule

// File: rtl/led_scan_driver.sv
// led_scan_driver: multiplexed digit scan with blanking guard, brightness PWM,
// DP-off mask and a seg_in snapshot taken at the first cycle of every frame.
module led_scan_driver import led_pkg::*; #(
   parameter int N_DIGITS        = 4,
   parameter int SEG_W           = 8,
   parameter int SLOT_CYCLES     = 1000000,
   parameter int BLANK_CYCLES    = 2,
   parameter int BRIGHT_W        = 4,
   parameter bit SEL_ACTIVE_HIGH = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [N_DIGITS*SEG_W-1:0] seg_in,
   input  logic [N_DIGITS-1:0]       dp_off,
   input  logic [BRIGHT_W-1:0]       brightness,
   output logic [SEG_W-1:0]          seg_out,
   output logic [N_DIGITS-1:0]       sel_out,
   output logic                      frame_start
);
   localparam int CW = clog2(SLOT_CYCLES);
   localparam int IW = clog2(N_DIGITS);
   localparam logic [SEG_W-1:0] SEG_OFF = SEG_W'(seg_blank(SEG_W));
   logic                      slot_end;
   logic [CW-1:0]             count;
   logic [IW-1:0]             idx_d, idx_q;
   logic [N_DIGITS*SEG_W-1:0] masked, snap_d, snap_q;
   logic [BRIGHT_W-1:0]       pwm_d, pwm_q;
   logic [SEG_W-1:0]          seg_d, seg_q;
   logic [N_DIGITS-1:0]       sel_d, sel_q;
   logic                      snap_take, pwm_on;
   slot_state_e               state;

   led_prescaler #(.SLOT_CYCLES(SLOT_CYCLES)) u_prescaler (
      .clk(clk),
      .rst(rst),
      .clear(!enable),
      .slot_end(slot_end),
      .count(count)
   );

   // Disabling clears count and index, so the first enabled cycle lands on slot 0 of digit 0.
   always_comb begin
      masked = seg_in;
      for (int d = 0; d < N_DIGITS; d++)
         masked[d*SEG_W+SEG_W-1] = seg_in[d*SEG_W+SEG_W-1] | dp_off[d];
      state = (count < CW'(BLANK_CYCLES)) ? BLANK : DRIVE;
      snap_take = enable && count == '0 && idx_q == '0;
      pwm_on = (&brightness) || (pwm_q < brightness);
      idx_d = !enable ? '0 : !slot_end ? idx_q : (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      snap_d = snap_take ? masked : snap_q;
      pwm_d = pwm_q + 1'b1;
      seg_d = (enable && state == DRIVE) ? snap_q[idx_q*SEG_W +: SEG_W] : SEG_OFF;
      sel_d = (enable && state == DRIVE && pwm_on) ? N_DIGITS'(1) << idx_q : '0;
   end

   always_ff @(posedge clk)
      if (rst) begin
         idx_q <= '0;
         snap_q <= '1;
         pwm_q <= '0;
         seg_q <= SEG_OFF;
         sel_q <= '0;
      end else begin
         idx_q <= idx_d;
         snap_q <= snap_d;
         pwm_q <= pwm_d;
         seg_q <= seg_d;
         sel_q <= sel_d;
      end

   assign seg_out = seg_q;
   assign sel_out = SEL_ACTIVE_HIGH ? sel_q : ~sel_q;
   assign frame_start = snap_take && !rst;
endmodule

// File: doc/led_scan_driver.md
Name: led_scan_driver

Overview:
- Parametrised multiplexed 7-segment/LED scan driver.
- Cycles through N_DIGITS digit enables at a programmable slot rate.
- Adds a per-slot blanking guard against ghosting, a brightness PWM, a per-digit DP-off mask, and tear-free frame snapshotting.
- Sits between the clock/display formatting logic and the board's segment and digit-select pins.

Parameters:
- N_DIGITS, 4: number of multiplexed digits; must be >= 1.
- SEG_W, 8: segment bits per digit. Active-low; bit SEG_W-1 is the DP.
- SLOT_CYCLES, 1000000: clk cycles per digit slot; must be > BLANK_CYCLES + 1.
- BLANK_CYCLES, 2: cycles at the start of each slot with all selects inactive and segments off.
- BRIGHT_W, 4: brightness code width.
- SEL_ACTIVE_HIGH, 1: 1 means an active select bit is 1; 0 inverts all of sel_out.

Ports:
- clk, in, 1: system clock (50 MHz).
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: 0 blanks the display and holds the scan at digit 0.
- seg_in, in, N_DIGITS*SEG_W: digit d occupies bits [d*SEG_W +: SEG_W].
- dp_off, in, N_DIGITS: 1 forces the DP bit of digit d to 1 (off).
- brightness, in, BRIGHT_W: 0 means dark; all-ones means full on.
- seg_out, out, SEG_W: registered segment drive, active-low.
- sel_out, out, N_DIGITS: registered one-hot digit select, polarity per SEL_ACTIVE_HIGH.
- frame_start, out, 1: one-cycle pulse in the cycle the snapshot is taken.

Behaviour:
- Reset (rst=1 at posedge clk) and the values it sets:
  - seg_out = all ones.
  - sel_out = all inactive.
  - frame_start = 0.
  - Slot counter, digit index and PWM counter = 0.
  - Snapshot register = all ones.
  - Reset takes effect mid-slot and mid-frame with no partial digit completed.
- Slot counter: counts 0..SLOT_CYCLES-1, then wraps to 0. slot_end is asserted when count == SLOT_CYCLES-1.
- Digit index: advances on slot_end and wraps from N_DIGITS-1 to 0.
- Snapshot: taken in the cycle where (index wraps to 0) or (first enabled cycle after reset or after enable was low).
  - Captures seg_in with dp_off already applied.
  - Pulses frame_start in that same cycle.
  - Changes to seg_in or dp_off mid-frame never appear until the next frame.
- Per-slot FSM:
  - BLANK: slot count < BLANK_CYCLES. sel_out inactive, seg_out all ones.
  - DRIVE: remaining cycles. seg_out = snapshot digit[index]. sel_out bit[index] is active only while pwm_on, all other bits inactive.
  - Outputs are registered, so the pins lag the internal state by 1 cycle.
- PWM:
  - pwm_cnt is a free-running BRIGHT_W-bit counter, reset only by rst.
  - pwm_on = (brightness == all ones) OR (pwm_cnt < brightness).
  - brightness = 0 means the select is never active.
  - brightness is sampled every cycle; no synchronisation is required.
- enable = 0:
  - Next cycle: outputs blanked as in reset.
  - Slot counter and index forced to 0.
  - Snapshot retained.
- enable rising: the first enabled cycle takes a snapshot and starts digit 0 in BLANK.
- rst and enable: rst has priority over everything.
- Invariant: at most one sel_out bit is active in any cycle.
- N_DIGITS = 1: the index stays 0 and a snapshot is taken every slot.

Decomposition:
- Package led_pkg:
  - SEG_BLANK (all-ones constant function of SEG_W).
  - Function clog2.
  - FSM state encoding: BLANK = 1'b0, DRIVE = 1'b1.
- Sub-module led_prescaler:
  - Parameterised SLOT_CYCLES counter with clear input.
  - Outputs slot_end and count.
  - Reused by other timebase blocks.
- Top module holds: index, snapshot, FSM, PWM and output registers.

Test Plan:
Configuration for all scenarios: N_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2, BRIGHT_W=2, brightness=3.
1. Reset then scan:
   - Stimulus: seg_in=0x11223344, dp_off=0, enable=1.
   - Required: sel_out inactive for 2 cycles, then 0001 with seg_out=0x44 for 6 cycles.
   - Then 0010/0x33, 0100/0x22, 1000/0x11, then back to 0001.
   - frame_start pulses every 32 cycles.
2. Tearing:
   - Stimulus: change seg_in to 0xAABBCCDD during digit 2.
   - Required: digits 2 and 3 still show 0x22 and 0x11; the next frame shows 0xDD first.
3. DP mask:
   - Stimulus: dp_off=4'b0100, seg_in digit 2 = 0x22.
   - Required: seg_out=0xA2 during digit 2's DRIVE window; other digits unchanged.
4. Brightness:
   - brightness=1: in DRIVE, the select is active in exactly 1 of every 4 cycles (pwm_cnt=0).
   - brightness=0: sel_out is never active for 64 cycles.
5. Enable and reset mid-slot:
   - Stimulus: drop enable in cycle 5 of digit 1.
   - Required: next cycle blanked; on re-enable, frame_start pulses and digit 0 starts in BLANK.
   - Same check for rst=1 mid-slot: all outputs return to reset values next cycle.
6. Polarity and one-hot:
   - Stimulus: SEL_ACTIVE_HIGH=0, N_DIGITS=1.
   - Required: sel_out=0 only during DRIVE with pwm_on, otherwise 1.
   - An assertion checks at most one active select bit in every cycle.
